// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, element-width, func and ctrl-field constants for ex_alu
package alu_pkg;

   localparam logic [5:0] ALU_OPCODE = 6'b101010;

   localparam logic [1:0] WW_8  = 2'b00;
   localparam logic [1:0] WW_16 = 2'b01;
   localparam logic [1:0] WW_32 = 2'b10;
   localparam logic [1:0] WW_64 = 2'b11;

   typedef enum logic [5:0] {
      F_VAND   = 6'd0,
      F_VOR    = 6'd1,
      F_VXOR   = 6'd2,
      F_VNOT   = 6'd3,
      F_VMOV   = 6'd4,
      F_VADD   = 6'd5,
      F_VSUB   = 6'd6,
      F_VMULEU = 6'd7,
      F_VMULOU = 6'd8,
      F_VRTTH  = 6'd9,
      F_VSLL   = 6'd10,
      F_VSLLI  = 6'd11,
      F_VSRL   = 6'd12,
      F_VSRLI  = 6'd13,
      F_VSRA   = 6'd14,
      F_VSRAI  = 6'd15
   } alu_func_e;

   // Slice positions within ex_alu_ctrl[0:13], bit 0 is the MSB.
   localparam int CTRL_OPC_LO  = 0;
   localparam int CTRL_OPC_HI  = 5;
   localparam int CTRL_WW_LO   = 6;
   localparam int CTRL_WW_HI   = 7;
   localparam int CTRL_FUNC_LO = 8;
   localparam int CTRL_FUNC_HI = 13;

   typedef enum logic [1:0] {
      SH_LL = 2'd0,
      SH_RL = 2'd1,
      SH_RA = 2'd2
   } shift_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - element-wise sll/srl/sra over 8/16/32/64-bit lanes selected by ww
module alu_shifter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [4:0]            imm_i,
   input  logic                  use_imm_i,
   input  logic [1:0]            ww_i,
   input  shift_kind_e           kind_i,
   output logic [DATA_WIDTH-1:0] res_o
);

   logic [3:0][DATA_WIDTH-1:0] res_w;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      localparam int W = 8 << g;
      for (genvar i = 0; i < DATA_WIDTH / W; i++) begin : g_elem
         logic [W-1:0] a_e;
         logic [W-1:0] amt;
         logic [W-1:0] sra_e;
         assign a_e   = a_i[i*W +: W];
         // Keep the low log2(W) bits; the 5-bit immediate caps 64-bit lanes at 31.
         assign amt   = (use_imm_i ? W'(imm_i) : b_i[i*W +: W]) & W'(W - 1);
         assign sra_e = $unsigned($signed(a_e) >>> amt);
         assign res_w[g][i*W +: W] = (kind_i == SH_LL) ? (a_e << amt) :
                                     (kind_i == SH_RL) ? (a_e >> amt) : sra_e;
      end
   end

   assign res_o = res_w[ww_i];

endmodule

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - registered SIMD vector ALU, one op per cycle, latency 1
// Optional ALU_MUL_EN enables vmuleu/vmulou; otherwise func 7/8 decode as invalid.
module ex_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [0:DATA_WIDTH-1] ra,
   input  logic [0:DATA_WIDTH-1] rb,
   input  logic [0:13]           ex_alu_ctrl,
   input  logic                  ex2alu_regwrite,
   input  logic [0:4]            alu_imme,
   output logic [0:DATA_WIDTH-1] alu_out,
   output logic                  alu2wb_regwirte
);

   logic [DATA_WIDTH-1:0] a, b, res, sh_res, out_d, out_q;
   logic [5:0]            opcode;
   logic [1:0]            ww;
   logic [4:0]            imm;
   alu_func_e             func;
   shift_kind_e           sh_kind;
   logic                  use_imm, valid, wb_d, wb_q;

   // Descending copies keep the vector MSB at the top index for lane arithmetic.
   assign a      = ra;
   assign b      = rb;
   assign imm    = alu_imme;
   assign opcode = ex_alu_ctrl[CTRL_OPC_LO:CTRL_OPC_HI];
   assign ww     = ex_alu_ctrl[CTRL_WW_LO:CTRL_WW_HI];
   assign func   = alu_func_e'(ex_alu_ctrl[CTRL_FUNC_LO:CTRL_FUNC_HI]);

   logic [3:0][DATA_WIDTH-1:0] add_w, sub_w, rtth_w;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      localparam int W = 8 << g;
      for (genvar i = 0; i < DATA_WIDTH / W; i++) begin : g_elem
         assign add_w[g][i*W +: W]  = a[i*W +: W] + b[i*W +: W];
         assign sub_w[g][i*W +: W]  = a[i*W +: W] - b[i*W +: W];
         assign rtth_w[g][i*W +: W] = {a[i*W +: W/2], a[i*W + W/2 +: W/2]};
      end
   end

`ifdef ALU_MUL_EN
   logic [3:0][DATA_WIDTH-1:0] mule_w, mulo_w;
   assign mule_w[3] = '0;
   assign mulo_w[3] = '0;

   // Element 0 is the MSB, so the even element of each pair is its upper half.
   for (genvar g = 0; g < 3; g++) begin : g_mul
      localparam int W = 8 << g;
      for (genvar j = 0; j < DATA_WIDTH / (2*W); j++) begin : g_pair
         localparam int P = j * 2 * W;
         assign mule_w[g][P +: 2*W] = {{W{1'b0}}, a[P+W +: W]} * {{W{1'b0}}, b[P+W +: W]};
         assign mulo_w[g][P +: 2*W] = {{W{1'b0}}, a[P +: W]} * {{W{1'b0}}, b[P +: W]};
      end
   end
`endif

   always_comb begin
      sh_kind = SH_LL;
      case (func)
         F_VSRL, F_VSRLI: sh_kind = SH_RL;
         F_VSRA, F_VSRAI: sh_kind = SH_RA;
         default: ;
      endcase
   end

   assign use_imm = (func == F_VSLLI) || (func == F_VSRLI) || (func == F_VSRAI);

   alu_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
      .a_i      (a),
      .b_i      (b),
      .imm_i    (imm),
      .use_imm_i(use_imm),
      .ww_i     (ww),
      .kind_i   (sh_kind),
      .res_o    (sh_res)
   );

   always_comb begin
      res   = '0;
      valid = 1'b1;
      case (func)
         F_VAND:  res = a & b;
         F_VOR:   res = a | b;
         F_VXOR:  res = a ^ b;
         F_VNOT:  res = ~a;
         F_VMOV:  res = a;
         F_VADD:  res = add_w[ww];
         F_VSUB:  res = sub_w[ww];
`ifdef ALU_MUL_EN
         F_VMULEU: begin
            res   = mule_w[ww];
            valid = (ww != WW_64);
         end
         F_VMULOU: begin
            res   = mulo_w[ww];
            valid = (ww != WW_64);
         end
`endif
         F_VRTTH: res = rtth_w[ww];
         F_VSLL, F_VSLLI, F_VSRL, F_VSRLI, F_VSRA, F_VSRAI: res = sh_res;
         default: valid = 1'b0;
      endcase
      if (opcode != ALU_OPCODE) valid = 1'b0;
   end

   assign out_d = valid ? res : '0;
   assign wb_d  = valid & ex2alu_regwrite;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         wb_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         wb_q  <= wb_d;
      end
   end

   assign alu_out         = out_q;
   assign alu2wb_regwirte = wb_q;

endmodule

// File: tb/tb_ex_alu.sv
// tb/tb_ex_alu.sv - randomized self-checking bench for ex_alu against an element-level model
module tb_ex_alu;

   logic        clk;
   logic        rst;
   logic [0:63] ra, rb, alu_out;
   logic [0:13] ex_alu_ctrl;
   logic [0:4]  alu_imme;
   logic        ex2alu_regwrite, alu2wb_regwirte;

   int n_cmp = 0;
   int n_err = 0;

`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [5:0]  opc;
      logic [1:0]  ww;
      logic [5:0]  fn;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  imm;
      logic        we;
      logic [63:0] exp;
      logic        exp_wb;
   } vec_t;

   vec_t vecs[$];

   ex_alu #(.DATA_WIDTH(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .ra             (ra),
      .rb             (rb),
      .ex_alu_ctrl    (ex_alu_ctrl),
      .ex2alu_regwrite(ex2alu_regwrite),
      .alu_imme       (alu_imme),
      .alu_out        (alu_out),
      .alu2wb_regwirte(alu2wb_regwirte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   function automatic longint unsigned lane_mask(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic longint unsigned elem(input longint unsigned x, input int w, input int e);
      return (x >> (64 - (e + 1) * w)) & lane_mask(w);
   endfunction

   function automatic logic [63:0] ref_alu(input logic [5:0] opc, input logic [1:0] ww,
                                           input logic [5:0] fn, input longint unsigned a,
                                           input longint unsigned b, input logic [4:0] imm,
                                           output bit ok);
      int w, sh;
      longint unsigned m, ae, be, v, r, src;
      w  = 8 << ww;
      m  = lane_mask(w);
      ok = (opc == 6'd42) && (fn < 16) &&
           !((fn == 7 || fn == 8) && (!MUL_EN || ww == 2'd3));
      r  = 0;
      if (!ok) return 64'd0;
      if (fn <= 4) begin
         case (fn)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~a;
            default: r = a;
         endcase
         return r;
      end
      if (fn == 7 || fn == 8) begin
         for (int k = 0; k < 32 / w; k++) begin
            ae = elem(a, w, 2 * k + ((fn == 8) ? 1 : 0));
            be = elem(b, w, 2 * k + ((fn == 8) ? 1 : 0));
            r |= (ae * be) << (64 - (k + 1) * 2 * w);
         end
         return r;
      end
      for (int e = 0; e < 64 / w; e++) begin
         ae  = elem(a, w, e);
         be  = elem(b, w, e);
         src = (fn == 11 || fn == 13 || fn == 15) ? longint'(imm) : be;
         sh  = int'(src % longint'(w));
         case (fn)
            5:       v = ae + be;
            6:       v = ae - be;
            9:       v = (ae >> (w / 2)) | (ae << (w / 2));
            10, 11:  v = ae << sh;
            12, 13:  v = ae >> sh;
            default: begin
               v = ae >> sh;
               if (((ae >> (w - 1)) & 64'd1) != 0) v |= m & ~(m >> sh);
            end
         endcase
         r |= (v & m) << (64 - (e + 1) * w);
      end
      return r;
   endfunction

   task automatic drive(input logic [5:0] opc, input logic [1:0] ww, input logic [5:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] imm,
                        input logic we);
      ra              = a;
      rb              = b;
      ex_alu_ctrl     = {opc, ww, fn};
      alu_imme        = imm;
      ex2alu_regwrite = we;
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string name, input logic [5:0] opc, input logic [1:0] ww,
                          input logic [5:0] fn, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] imm, input logic we, input logic [63:0] exp,
                          input logic exp_wb);
      vec_t v;
      v.name = name; v.opc = opc; v.ww = ww; v.fn = fn; v.a = a; v.b = b;
      v.imm = imm; v.we = we; v.exp = exp; v.exp_wb = exp_wb;
      vecs.push_back(v);
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      ra              = 64'h0123_4567_89AB_CDEF;
      rb              = 64'h1111_1111_1111_1111;
      ex_alu_ctrl     = {6'd42, 2'b00, 6'd1};
      alu_imme        = 5'd3;
      ex2alu_regwrite = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (alu_out !== 64'd0) begin
         n_err++;
         $display("FAIL reset_out: got %h expected %h", alu_out, 64'd0);
      end
      n_cmp++;
      if (alu2wb_regwirte !== 1'b0) begin
         n_err++;
         $display("FAIL reset_wb: got %b expected 0", alu2wb_regwirte);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      add_vec("vadd_b", 6'd42, 2'b00, 6'd5, 64'h01FF_0000_0000_0000, 64'h0101_0000_0000_0000, 5'd0, 1'b1, 64'h0200_0000_0000_0000, 1'b1);
      add_vec("vsub_h", 6'd42, 2'b01, 6'd6, 64'h0, 64'h0001_0000_0000_0000, 5'd0, 1'b1, 64'hFFFF_0000_0000_0000, 1'b1);
      add_vec("vsrai_w", 6'd42, 2'b10, 6'd15, 64'h8000_0000_0000_0010, 64'h0, 5'd4, 1'b1, 64'hF800_0000_0000_0001, 1'b1);
      add_vec("vrtth_d", 6'd42, 2'b11, 6'd9, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd0, 1'b1, 64'h89AB_CDEF_0123_4567, 1'b1);
      add_vec("vrtth_nowe", 6'd42, 2'b11, 6'd9, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd0, 1'b0, 64'h89AB_CDEF_0123_4567, 1'b0);
      add_vec("bad_opcode", 6'd0, 2'b00, 6'd4, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 5'd0, 1'b1, 64'h0, 1'b0);
      add_vec("bad_func16", 6'd42, 2'b00, 6'd16, 64'hDEAD_BEEF_DEAD_BEEF, 64'hFFFF, 5'd0, 1'b1, 64'h0, 1'b0);
      add_vec("vsll_d_wrap", 6'd42, 2'b11, 6'd10, 64'h1, 64'h41, 5'd0, 1'b1, 64'h2, 1'b1);
      add_vec("vslli_d_31", 6'd42, 2'b11, 6'd11, 64'h1, 64'h0, 5'd31, 1'b1, 64'h8000_0000, 1'b1);
      add_vec("vsrl_b", 6'd42, 2'b00, 6'd12, 64'h8000_0000_0000_0000, 64'h0900_0000_0000_0000, 5'd0, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
      add_vec("vmuleu_b", 6'd42, 2'b00, 6'd7, 64'hFF02_0000_0000_0000, 64'hFF03_0000_0000_0000, 5'd0, 1'b1,
              MUL_EN ? 64'hFE01_0000_0000_0000 : 64'h0, MUL_EN);
      add_vec("vmulou_b", 6'd42, 2'b00, 6'd8, 64'hFF02_0000_0000_0000, 64'hFF03_0000_0000_0000, 5'd0, 1'b1,
              MUL_EN ? 64'h0006_0000_0000_0000 : 64'h0, MUL_EN);
      add_vec("vmul_d_bad", 6'd42, 2'b11, 6'd7, 64'hFFFF, 64'hFFFF, 5'd0, 1'b1, 64'h0, 1'b0);
      foreach (vecs[i]) begin
         drive(vecs[i].opc, vecs[i].ww, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].we);
         n_cmp++;
         if (alu_out !== vecs[i].exp) begin
            n_err++;
            $display("FAIL %s_out: got %h expected %h", vecs[i].name, alu_out, vecs[i].exp);
         end
         n_cmp++;
         if (alu2wb_regwirte !== vecs[i].exp_wb) begin
            n_err++;
            $display("FAIL %s_wb: got %b expected %b", vecs[i].name, alu2wb_regwirte, vecs[i].exp_wb);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 400; n++) begin
         logic [5:0]  opc, fn;
         logic [1:0]  ww;
         logic [63:0] a, b, exp;
         logic [4:0]  imm;
         logic        we;
         bit          ok;
         opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd42;
         fn  = 6'($urandom_range(0, 19));
         ww  = 2'($urandom);
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         imm = 5'($urandom);
         we  = 1'($urandom);
         exp = ref_alu(opc, ww, fn, a, b, imm, ok);
         drive(opc, ww, fn, a, b, imm, we);
         n_cmp++;
         if (alu_out !== exp) begin
            n_err++;
            $display("FAIL rand_out[%0d] op=%0d ww=%0d fn=%0d a=%h b=%h imm=%0d: got %h expected %h",
                     n, opc, ww, fn, a, b, imm, alu_out, exp);
         end
         n_cmp++;
         if (alu2wb_regwirte !== (ok & we)) begin
            n_err++;
            $display("FAIL rand_wb[%0d] fn=%0d: got %b expected %b", n, fn, alu2wb_regwirte, ok & we);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(6'd42, 2'b00, 6'd5, 64'h01FF_0000_0000_0000, 64'h0101_0000_0000_0000, 5'd0, 1'b1);
      n_cmp++;
      if (alu_out !== 64'h0200_0000_0000_0000 || alu2wb_regwirte !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset: got %h/%b expected %h/1", alu_out, alu2wb_regwirte, 64'h0200_0000_0000_0000);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (alu_out !== 64'd0 || alu2wb_regwirte !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got %h/%b expected 0/0", alu_out, alu2wb_regwirte);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (alu_out !== 64'd0 || alu2wb_regwirte !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: got %h/%b expected 0/0", alu_out, alu2wb_regwirte);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (alu_out !== 64'h0200_0000_0000_0000 || alu2wb_regwirte !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset: got %h/%b expected %h/1", alu_out, alu2wb_regwirte, 64'h0200_0000_0000_0000);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
